// File: rtl/mem_copy_engine_if.sv
// Memory bus between the copy engine and the single-pointer data memory.
//   DataAddress : shared address pointer (read and write)
//   MemWrite    : write enable, memory writes on the Clk edge
//   MemWrData   : data driven into memory DataIn
//   MemRdData   : memory DataOut, combinational from DataAddress
// master = engine side, slave = memory side.
interface mem_copy_engine_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] DataAddress;
    logic          MemWrite;
    logic [DW-1:0] MemWrData;
    logic [DW-1:0] MemRdData;

    modport master (output DataAddress, output MemWrite, output MemWrData, input MemRdData);
    modport slave  (input DataAddress, input MemWrite, input MemWrData, output MemRdData);
endinterface

// File: rtl/mem_copy_engine.sv
// Block copy / fill engine for a single-pointer 2**AW x DW data memory.
// Copy alternates RD (read source byte into hold) and WR (write it to the
// destination); fill issues back-to-back WR cycles of a latched constant.
// Ports:
//   Clk, Reset   : clock, synchronous active-high reset
//   Start        : request pulse, only looked at in IDLE
//   Mode         : 0 = copy, 1 = fill
//   SrcAddr      : copy source base
//   DstAddr      : destination base
//   Length       : byte count 0..2**AW (AW+1 bits)
//   FillValue    : fill constant
//   mem          : memory bus (master side)
//   Busy         : high in RD and WR
//   Done         : one-cycle completion pulse (FIN)
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Mode,
    input  logic [AW-1:0] SrcAddr,
    input  logic [AW-1:0] DstAddr,
    input  logic [AW:0]   Length,
    input  logic [DW-1:0] FillValue,
    mem_copy_engine_if.master mem,
    output logic          Busy,
    output logic          Done
);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] src_ptr, dst_ptr;
    logic [AW:0]   cnt;
    logic          mode_q;
    logic [DW-1:0] fill_q;
    logic [DW-1:0] hold;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Outputs depend only on state and registers, so nothing from the
    // request inputs reaches the memory bus combinationally.
    always_comb begin
        state_nxt       = state;
        mem.DataAddress = '0;
        mem.MemWrite    = 1'b0;
        mem.MemWrData   = '0;
        Busy            = 1'b0;
        Done            = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Length == '0) state_nxt = FIN;
                    else if (Mode)    state_nxt = WR;
                    else              state_nxt = RD;
                end
            end
            RD: begin
                mem.DataAddress = src_ptr;
                Busy            = 1'b1;
                state_nxt       = WR;
            end
            WR: begin
                mem.DataAddress = dst_ptr;
                mem.MemWrite    = 1'b1;
                mem.MemWrData   = mode_q ? fill_q : hold;
                Busy            = 1'b1;
                if (cnt == (AW+1)'(1)) state_nxt = FIN;
                else if (mode_q)       state_nxt = WR;
                else                   state_nxt = RD;
            end
            FIN: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pointers advance together after every write; AW-bit wrap gives the
    // modulo-depth behaviour, and Length = 2**AW brings both back to base.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
            mode_q  <= 1'b0;
            fill_q  <= '0;
            hold    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        src_ptr <= SrcAddr;
                        dst_ptr <= DstAddr;
                        cnt     <= Length;
                        mode_q  <= Mode;
                        fill_q  <= FillValue;
                    end
                end
                RD: hold <= mem.MemRdData;
                WR: begin
                    src_ptr <= src_ptr + 1'b1;
                    dst_ptr <= dst_ptr + 1'b1;
                    cnt     <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;
    logic       Clk = 1'b0;
    logic       Reset, Start, Mode;
    logic [7:0] SrcAddr, DstAddr, FillValue;
    logic [8:0] Length;
    logic       Busy, Done;

    mem_copy_engine_if #(.AW(8), .DW(8)) bus ();

    mem_copy_engine #(.AW(8), .DW(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode),
        .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length), .FillValue(FillValue),
        .mem(bus.master), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Bench memory: combinational read, clocked write. Preload port shares
    // the write process so the array has a single writer.
    logic [7:0] mem [256];
    logic [7:0] exp_mem [256];
    logic       pre_we = 1'b0;
    logic [7:0] pre_addr = '0, pre_data = '0;

    assign bus.MemRdData = mem[bus.DataAddress];

    always @(posedge Clk) begin
        if (pre_we)            mem[pre_addr] <= pre_data;
        else if (bus.MemWrite) mem[bus.DataAddress] <= bus.MemWrData;
    end

    int passed = 0, total = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        exp_mem[a] = d;
        @(negedge Clk);
        pre_we = 1'b0;
    endtask

    task automatic check_mem(input string nm);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        check({nm, " mem_mismatches"}, bad, 0);
    endtask

    // Reference: forward byte-by-byte transfer on the expected image, which
    // yields the overlap replication naturally. The bus is then checked cycle
    // by cycle against the timing rules (copy: odd=read, even=write; fill:
    // every busy cycle writes).
    task automatic run_op(input bit mode, input logic [7:0] src, input logic [7:0] dst,
                          input int len, input logic [7:0] fill, input int exp_done,
                          input int restart_at, input string nm);
        logic [7:0] wq[$];
        int done_cyc = 0, done_cnt = 0, wr_bad = 0, busy_bad = 0, addr_bad = 0, data_bad = 0;
        for (int i = 0; i < len; i++) begin
            logic [7:0] v;
            v = mode ? fill : exp_mem[8'(src + i)];
            exp_mem[8'(dst + i)] = v;
            wq.push_back(v);
        end
        @(negedge Clk);
        Start = 1'b1; Mode = mode; SrcAddr = src; DstAddr = dst;
        Length = 9'(len); FillValue = fill;
        @(negedge Clk);
        Start = 1'b0;
        Mode = 1'($urandom); SrcAddr = 8'($urandom); DstAddr = 8'($urandom);
        Length = 9'($urandom); FillValue = 8'($urandom);
        for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
            bit         exp_busy, exp_wr;
            logic [7:0] exp_a;
            int         k;
            exp_busy = (cyc < exp_done);
            exp_a    = 8'h00;
            exp_wr   = 1'b0;
            k        = 0;
            if (exp_busy) begin
                if (mode) begin
                    exp_wr = 1'b1; k = cyc - 1; exp_a = 8'(dst + k);
                end else if (cyc % 2 == 0) begin
                    exp_wr = 1'b1; k = cyc / 2 - 1; exp_a = 8'(dst + k);
                end else begin
                    exp_a = 8'(src + (cyc - 1) / 2);
                end
            end
            if (bus.MemWrite !== exp_wr) wr_bad++;
            if (Busy !== exp_busy) busy_bad++;
            if (bus.DataAddress !== exp_a) addr_bad++;
            if (exp_wr && k < wq.size() && bus.MemWrData !== wq[k]) data_bad++;
            if (Done === 1'b1) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
            if (cyc == restart_at) begin
                Start = 1'b1; Mode = 1'($urandom); SrcAddr = 8'($urandom);
                DstAddr = 8'($urandom); Length = 9'($urandom_range(1, 20));
            end else begin
                Start = 1'b0;
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        check({nm, " done_cycle"}, done_cyc, exp_done);
        check({nm, " done_pulses"}, done_cnt, 1);
        check({nm, " memwrite_pattern_errs"}, wr_bad, 0);
        check({nm, " busy_errs"}, busy_bad, 0);
        check({nm, " address_errs"}, addr_bad, 0);
        check({nm, " wrdata_errs"}, data_bad, 0);
        check_mem(nm);
    endtask

    typedef struct {
        string      name;
        bit         mode;
        logic [7:0] src, dst;
        int         len;
        logic [7:0] fill;
        int         exp_done;
        int         restart_at;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"copy4",        1'b0, 8'h10, 8'h80, 4, 8'h00, 9, 0};
        vecs[1] = '{"fill_wrap",    1'b1, 8'h00, 8'hFE, 3, 8'h5A, 4, 0};
        vecs[2] = '{"len0",         1'b0, 8'h33, 8'h44, 0, 8'h00, 1, 0};
        vecs[3] = '{"overlap",      1'b0, 8'h20, 8'h21, 3, 8'h00, 7, 0};
        vecs[4] = '{"src_eq_dst",   1'b0, 8'h50, 8'h50, 5, 8'h00, 11, 0};
        vecs[5] = '{"start_busy",   1'b0, 8'h10, 8'h90, 4, 8'h00, 9, 3};
        vecs[6] = '{"start_in_fin", 1'b1, 8'h00, 8'h60, 2, 8'h77, 3, 3};

        Reset = 1'b1; Start = 1'b0; Mode = 1'b0; SrcAddr = '0; DstAddr = '0;
        Length = '0; FillValue = '0;
        repeat (3) @(negedge Clk);
        check("reset DataAddress", int'(bus.DataAddress), 0);
        check("reset MemWrite", int'(bus.MemWrite), 0);
        check("reset MemWrData", int'(bus.MemWrData), 0);
        check("reset Busy", int'(Busy), 0);
        check("reset Done", int'(Done), 0);
        Reset = 1'b0;

        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
        poke(8'h20, 8'h11); poke(8'h21, 8'h22);

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill,
                   vecs[i].exp_done, vecs[i].restart_at, vecs[i].name);

        // Literal outcomes from the plan, independent of the reference image.
        check("copy4 dst80", int'(mem[8'h80]), 'hA1);
        check("copy4 dst83", int'(mem[8'h83]), 'hD4);
        check("fill_wrap FF", int'(mem[8'hFF]), 'h5A);
        check("fill_wrap 00", int'(mem[8'h00]), 'h5A);
        check("overlap 21", int'(mem[8'h21]), 'h11);
        check("overlap 23", int'(mem[8'h23]), 'h11);

        // Reset in cycle 5 of an 8-byte copy: only the first two bytes land.
        for (int i = 0; i < 8; i++) poke(8'(8'h30 + i), 8'(8'hE0 + i));
        exp_mem[8'hB0] = exp_mem[8'h30];
        exp_mem[8'hB1] = exp_mem[8'h31];
        @(negedge Clk);
        Start = 1'b1; Mode = 1'b0; SrcAddr = 8'h30; DstAddr = 8'hB0; Length = 9'd8;
        @(negedge Clk);
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("rst_mid MemWrite", int'(bus.MemWrite), 0);
        check("rst_mid Busy", int'(Busy), 0);
        check("rst_mid Done", int'(Done), 0);
        check("rst_mid DataAddress", int'(bus.DataAddress), 0);
        repeat (10) @(negedge Clk);
        check_mem("rst_mid");
        run_op(1'b0, 8'h30, 8'hB0, 8, 8'h00, 17, 0, "after_reset");

        // Randomized operations against the reference image.
        for (int t = 0; t < 24; t++) begin
            bit         m;
            int         n, ed;
            m  = 1'($urandom);
            n  = $urandom_range(0, 12);
            ed = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
            run_op(m, 8'($urandom), 8'($urandom), n, 8'($urandom), ed,
                   $urandom_range(0, ed), $sformatf("rand%0d", t));
        end

        run_op(1'b1, 8'h00, 8'h00, 256, 8'hC3, 257, 0, "fill_full");
        run_op(1'b0, 8'h40, 8'hC0, 256, 8'h00, 513, 0, "copy_full");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator for the single-pointer, 256x8 data memory: combinational read, write on the Clk edge when MemWrite is high.
- Copies a block of bytes from one address range to another, or fills a range with a constant.
- Sits beside the core. Drives the memory's DataAddress/MemWrite/DataIn ports and samples its DataOut.
- While Busy is high, the engine is the only source of memory traffic. External muxing is outside this block.

Parameters:
- AW, 8, address width; memory depth is 2**AW.
- DW, 8, data width.

Ports:
- Clk  input  1  clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request pulse; sampled only in IDLE.
- Mode  input  1  0 = copy, 1 = fill.
- SrcAddr  input  AW  copy source base; ignored in fill mode.
- DstAddr  input  AW  destination base.
- Length  input  AW+1  byte count, 0..2**AW.
- FillValue  input  DW  fill constant.
- MemRdData  input  DW  memory DataOut, combinational from DataAddress.
- DataAddress  output  AW  memory address pointer.
- MemWrite  output  1  memory write enable.
- MemWrData  output  DW  memory DataIn.
- Busy  output  1  high in RD and WR states.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, RD, WR, FIN. All outputs are decoded from registered state and registers; there are no input-to-output combinational paths.
- Reset: state goes to IDLE; internal pointers, count and hold register clear to 0. Outputs: DataAddress=0, MemWrite=0, MemWrData=0, Busy=0, Done=0.
- Reset mid-operation: MemWrite is 0 in the cycle after the reset edge. No further writes occur; the partial transfer is abandoned.
- IDLE, Start=1:
  - Latch src_ptr=SrcAddr, dst_ptr=DstAddr, cnt=Length, mode=Mode, fill=FillValue.
  - Next state: Length==0 -> FIN; otherwise copy -> RD, fill -> WR.
- Start outside IDLE is ignored; inputs other than Start are don't-care outside the latching edge.
- RD:
  - DataAddress=src_ptr, MemWrite=0.
  - At the edge: hold<=MemRdData; go to WR.
- WR:
  - DataAddress=dst_ptr, MemWrite=1, MemWrData = hold (copy) or fill (fill).
  - At the edge: dst_ptr+=1 and src_ptr+=1, both modulo 2**AW, so 255 wraps to 0. cnt-=1.
  - If cnt was 1, go to FIN. Otherwise copy -> RD, fill -> WR.
- FIN: Done=1, Busy=0, MemWrite=0; next state IDLE. A Start in FIN is ignored.
- Cycle counts from the Start edge to the Done cycle:
  - Copy: 2N cycles of RD/WR, then Done in cycle 2N+1.
  - Fill: N WR cycles, Done in cycle N+1.
  - Length 0: Done in cycle 1 with no memory access.
- Length=256 (AW+1 bit value 2**AW) transfers the full memory; the pointers wrap back to their bases.
- Overlap: copy is strictly forward, byte by byte; each write lands before the next read. If dst is in (src, src+N), the result is a periodic replication of the first dst-src source bytes. This is defined behaviour, not an error.
- src==dst: the copy rewrites identical data and takes the full 2N cycles.
- The engine never asserts MemWrite outside WR.

Test Plan:
- Copy: preload mem[0x10..0x13]=A1,B2,C3,D4; Start, Mode=0, Src=0x10, Dst=0x80, Len=4.
  - mem[0x80..0x83]=A1,B2,C3,D4.
  - Done is high exactly in cycle 9 after Start; Busy is high in cycles 1..8.
  - MemWrite is high only in the even cycles 2, 4, 6, 8.
- Fill with wrap: Mode=1, Dst=0xFE, Len=3, FillValue=0x5A.
  - mem[0xFE], mem[0xFF], mem[0x00] are all 0x5A; mem[0x01] is unchanged.
  - Done in cycle 4.
- Length 0: Start with Len=0.
  - Done in cycle 1; MemWrite never asserts; memory is unchanged.
- Overlapping copy: mem[0x20..0x21]=11,22; Src=0x20, Dst=0x21, Len=3.
  - mem[0x21..0x23]=11,11,11.
- Reset mid-copy: Len=8 copy; assert Reset for 1 cycle at cycle 5.
  - Exactly 2 destination bytes are written.
  - The next cycle shows MemWrite=0, Busy=0, Done=0, DataAddress=0.
  - A new Start afterwards works normally.
- Start while busy: a second Start pulse during a Len=4 copy is ignored.
  - A single Done pulse occurs; no extra writes.
